// File: rtl/ripple_successor_counter.sv
// Parametrised up/down event counter with prescaler, load/clear, wrap or saturate, and a registered terminal-count pulse.
// Optional sticky overflow flag (ovf/ovf_clr) is built when RIPPLE_SUCCESSOR_COUNTER_OVF_EN is defined.
module ripple_successor_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX      = 9,
  parameter int unsigned PRESCALE = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             at_bound
`ifdef RIPPLE_SUCCESSOR_COUNTER_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX);
  localparam logic [7:0]       PSC_LAST = 8'(PRESCALE - 1);

  logic [7:0] psc;
  logic       psc_done;
  logic       step;

  // Next count for one step; the boundary case either wraps or holds.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur,
                                                  input logic             up);
    if (up) begin
      if (cur != MAX_Q) return cur + WIDTH'(1);
      return SATURATE ? MAX_Q : '0;
    end
    if (cur != '0) return cur - WIDTH'(1);
    return SATURATE ? '0 : MAX_Q;
  endfunction

  // Clamping here keeps q inside 0..MAX, so no other path needs a range check.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  assign at_bound = up_dn ? (q == MAX_Q) : (q == '0);
  assign psc_done = (psc == PSC_LAST);
  assign step     = !clr && !load && en && psc_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      psc <= '0;
      tc  <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      psc <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      q   <= clamp_load(load_val);
      psc <= '0;
      tc  <= 1'b0;
    end else if (en) begin
      if (psc_done) begin
        psc <= '0;
        q   <= step_count(q, up_dn);
        tc  <= at_bound;
      end else begin
        psc <= psc + 8'd1;
        tc  <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

`ifdef RIPPLE_SUCCESSOR_COUNTER_OVF_EN
  // A boundary step in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ovf <= 1'b0;
    else if (clr)               ovf <= 1'b0;
    else if (step && at_bound)  ovf <= 1'b1;
    else if (ovf_clr)           ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ripple_successor_counter.sv
// Directed bench for ripple_successor_counter: wrap, saturate and prescale instances share one stimulus stream.
// Overflow-flag checks are compiled in only when RIPPLE_SUCCESSOR_COUNTER_OVF_EN is defined.
module tb_ripple_successor_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       up_dn = 1'b0;

  logic [3:0] q_w, q_s, q_p;
  logic       tc_w, tc_s, tc_p;
  logic       ab_w, ab_s, ab_p;
`ifdef RIPPLE_SUCCESSOR_COUNTER_OVF_EN
  logic       ovf_clr = 1'b0;
  logic       ovf_w, ovf_s, ovf_p;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ripple_successor_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .q(q_w), .tc(tc_w), .at_bound(ab_w)
`ifdef RIPPLE_SUCCESSOR_COUNTER_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf_w)
`endif
  );

  ripple_successor_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .q(q_s), .tc(tc_s), .at_bound(ab_s)
`ifdef RIPPLE_SUCCESSOR_COUNTER_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf_s)
`endif
  );

  ripple_successor_counter #(.WIDTH(4), .MAX(9), .PRESCALE(3), .SATURATE(1'b0)) u_psc (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .q(q_p), .tc(tc_p), .at_bound(ab_p)
`ifdef RIPPLE_SUCCESSOR_COUNTER_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf_p)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_q[4];
    int exp_tc[4];

    // Reset state, before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_q_w", 32'(q_w), 0);
    check("rst_tc_w", 32'(tc_w), 0);
    check("rst_q_p", 32'(q_p), 0);
    check("rst_atb_down", 32'(ab_w), 1);
    #5 rst_n = 1'b1;

    // Reset mid-count
    en = 1'b1; up_dn = 1'b1;
    repeat (5) tick();
    check("pre_rst_q", 32'(q_w), 5);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_q", 32'(q_w), 0);
    check("async_rst_tc", 32'(tc_w), 0);
    en = 1'b0;
    #2 rst_n = 1'b1;

    // Wrap up
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_q", 32'(q_w), 0);
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check($sformatf("wrap_q%0d", i), 32'(q_w), 32'(i % 10));
      check($sformatf("wrap_tc%0d", i), 32'(tc_w), (i == 10) ? 1 : 0);
      check($sformatf("wrap_atb%0d", i), 32'(ab_w), (i == 9) ? 1 : 0);
    end

    // Saturate down
    en = 1'b0; load = 1'b1; load_val = 4'd2; tick(); load = 1'b0;
    check("sat_load_q", 32'(q_s), 2);
    check("sat_load_tc", 32'(tc_s), 0);
    en = 1'b1; up_dn = 1'b0;
    exp_q  = '{1, 0, 0, 0};
    exp_tc = '{0, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sat_q%0d", i), 32'(q_s), 32'(exp_q[i]));
      check($sformatf("sat_tc%0d", i), 32'(tc_s), 32'(exp_tc[i]));
    end

    // Prescale by 3, then a 2-cycle enable gap
    en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("psc_q%0d", i), 32'(q_p), 32'(i / 3));
    end
    tick();
    check("gap_q_a", 32'(q_p), 3);
    en = 1'b0;
    tick(); check("gap_hold1", 32'(q_p), 3);
    tick(); check("gap_hold2", 32'(q_p), 3);
    en = 1'b1;
    tick(); check("gap_q_b", 32'(q_p), 3);
    tick(); check("gap_step", 32'(q_p), 4);
    check("gap_tc", 32'(tc_p), 0);

    // Priority and load clamp
    en = 1'b0; clr = 1'b1; load = 1'b1; load_val = 4'd7;
    tick();
    check("prio_clr_q", 32'(q_w), 0);
    clr = 1'b0; load_val = 4'd15;
    tick();
    check("clamp_q", 32'(q_w), 9);
    check("clamp_tc", 32'(tc_w), 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    check("clamp_wrap_q", 32'(q_w), 0);
    check("clamp_wrap_tc", 32'(tc_w), 1);
    en = 1'b0;
    tick();
    check("tc_one_cycle", 32'(tc_w), 0);

`ifdef RIPPLE_SUCCESSOR_COUNTER_OVF_EN
    clr = 1'b1; tick(); clr = 1'b0;
    check("ovf_clr_by_clr", 32'(ovf_w), 0);
    load = 1'b1; load_val = 4'd9; tick(); load = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    check("ovf_set", 32'(ovf_w), 1);
    tick();
    check("ovf_sticky", 32'(ovf_w), 1);
    load = 1'b1; tick(); load = 1'b0;
    en = 1'b1; ovf_clr = 1'b1; tick(); en = 1'b0;
    check("ovf_set_wins", 32'(ovf_w), 1);
    check("ovf_set_wins_tc", 32'(tc_w), 1);
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf_w), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
